// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the free-running reference clock: PLL reset, lock wait with timeout,
// lock qualification, then system reset release. Define PLL_SEQ_LOSS_COUNT_EN to build the lock-loss counter.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 100,
    parameter int LOCK_TIMEOUT  = 10000,
    parameter int STABLE_CYCLES = 1000,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        reseq_req,
    output logic        pll_rst,
    output logic        sys_rst,
    output logic        ready,
    output logic        fault,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [3:0]         retry_q, retry_d;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic               pll_rst_q, sys_rst_q, ready_q, fault_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [15:0]        loss_q;
    logic               loss_inc;
`endif

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
        loss_inc = 1'b0;
`endif
        if (reseq_req) begin
            // Software request outranks every lock- or timer-driven transition.
            state_d = ST_RESET;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ((retry_q + 4'd1) == MAX_R) ? ST_FAULT : ST_RESET;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A lock dropout restarts the lock wait without charging a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    timer_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET;
`ifdef PLL_SEQ_LOSS_COUNT_EN
                        loss_inc = 1'b1;
`endif
                    end
                end
                ST_FAULT: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they update on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            sync_q    <= 2'b00;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
            loss_q    <= '0;
`endif
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
`ifdef PLL_SEQ_LOSS_COUNT_EN
            if (loss_inc && (loss_q != 16'hFFFF)) begin
                loss_q <= loss_q + 16'd1;
            end
`endif
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    assign loss_cnt  = loss_q;
`else
    assign loss_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: per-cycle expected output vectors are queued as
// stimulus is driven and compared one cycle later. Honours PLL_SEQ_LOSS_COUNT_EN.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RC = 4, TO = 20, SC = 8, MR = 2;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif
    localparam logic [2:0] S_R = 3'd0, S_W = 3'd1, S_S = 3'd2, S_RUN = 3'd3, S_F = 3'd4;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        reseq_req = 1'b0;
    logic        pll_rst, sys_rst, ready, fault;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] loss_cnt;

    int errors = 0;
    int checks = 0;
    logic [26:0] sb_q[$];
    logic [26:0] act;

    pll_lock_sequencer #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .reseq_req(reseq_req),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .state(state), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #50 refclk = ~refclk;

    assign act = {state, pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};

    // Expected output vector: {state, pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt}
    function automatic logic [26:0] ev(input logic [2:0] st, input int rt, input int loss);
        logic p, s, r, f;
        p = (st == S_R) || (st == S_F);
        s = (st != S_RUN);
        r = (st == S_RUN);
        f = (st == S_F);
        return {st, p, s, r, f, 4'(rt), (LOSS_EN ? 16'(loss) : 16'h0000)};
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reseq_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] exp;
        rst = 1'b1;
        pll_locked = 1'b1;
        reseq_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(ev(S_R, 0, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reset edge %0d: got %h required %h", i, act, exp);
            end
        end
        reseq_req = 1'b0;
        pll_locked = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [26:0] exp;
        logic [2:0] st;
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            pll_locked = (e >= 10);
            if (e < 4) st = S_R;
            else if (e < 12) st = S_W;
            else if (e < 20) st = S_S;
            else st = S_RUN;
            sb_q.push_back(ev(st, 0, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL nominal cycle %0d: got %h required %h", e, act, exp);
            end
        end
    endtask

    task automatic test_timeout_fault();
        logic [26:0] exp;
        logic [2:0] st;
        int rt;
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            reseq_req = (e == 56);
            if (e < 4) st = S_R;
            else if (e < 24) st = S_W;
            else if (e < 28) st = S_R;
            else if (e < 48) st = S_W;
            else if (e < 56) st = S_F;
            else if (e < 60) st = S_R;
            else st = S_W;
            if (e < 24) rt = 0;
            else if (e < 48) rt = 1;
            else if (e < 56) rt = 2;
            else rt = 0;
            sb_q.push_back(ev(st, rt, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL timeout_fault cycle %0d: got %h required %h", e, act, exp);
            end
        end
        reseq_req = 1'b0;
    endtask

    task automatic test_glitch_stable();
        logic [26:0] exp;
        logic [2:0] st;
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            pll_locked = ((e >= 10) && (e <= 14)) || (e >= 16);
            if (e < 4) st = S_R;
            else if (e < 12) st = S_W;
            else if (e < 17) st = S_S;
            else if (e == 17) st = S_W;
            else if (e < 26) st = S_S;
            else st = S_RUN;
            sb_q.push_back(ev(st, 0, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL glitch_stable cycle %0d: got %h required %h", e, act, exp);
            end
        end
    endtask

    // Continues from RUN at cycle 30 of the glitch scenario; ends in RUN at cycle 64.
    task automatic test_loss_in_run();
        logic [26:0] exp;
        logic [2:0] st;
        for (int e = 31; e <= 64; e++) begin
            pll_locked = !((e >= 31) && (e <= 34));
            reseq_req = (e == 50);
            if (e < 33) st = S_RUN;
            else if (e < 37) st = S_R;
            else if (e == 37) st = S_W;
            else if (e < 46) st = S_S;
            else if (e < 50) st = S_RUN;
            else if (e < 54) st = S_R;
            else if (e == 54) st = S_W;
            else if (e < 63) st = S_S;
            else st = S_RUN;
            sb_q.push_back(ev(st, 0, (e < 33) ? 0 : 1));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL loss_in_run cycle %0d: got %h required %h", e, act, exp);
            end
        end
        reseq_req = 1'b0;
    endtask

    // Continues from RUN with one recorded loss; rst and reseq_req coincide on edge 66.
    task automatic test_sync_reset();
        logic [26:0] exp;
        logic [2:0] st;
        for (int e = 65; e <= 75; e++) begin
            rst = (e == 66);
            reseq_req = (e == 66);
            pll_locked = 1'b1;
            if (e < 66) st = S_RUN;
            else if (e < 70) st = S_R;
            else if (e == 70) st = S_W;
            else st = S_S;
            sb_q.push_back(ev(st, 0, (e < 66) ? 1 : 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL sync_reset cycle %0d: got %h required %h", e, act, exp);
            end
        end
        rst = 1'b0;
        reseq_req = 1'b0;
    endtask

    task automatic test_reseq_stable();
        logic [26:0] exp;
        logic [2:0] st;
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 29; e++) begin
            pll_locked = (e >= 10);
            reseq_req = (e == 15);
            if (e < 4) st = S_R;
            else if (e < 12) st = S_W;
            else if (e < 15) st = S_S;
            else if (e < 19) st = S_R;
            else if (e == 19) st = S_W;
            else if (e < 28) st = S_S;
            else st = S_RUN;
            sb_q.push_back(ev(st, 0, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reseq_stable cycle %0d: got %h required %h", e, act, exp);
            end
        end
        reseq_req = 1'b0;
    endtask

    task automatic test_reseq_timeout();
        logic [26:0] exp;
        logic [2:0] st;
        int rt;
        pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 55; e++) begin
            reseq_req = (e == 48);
            if (e < 4) st = S_R;
            else if (e < 24) st = S_W;
            else if (e < 28) st = S_R;
            else if (e < 48) st = S_W;
            else if (e < 52) st = S_R;
            else st = S_W;
            rt = ((e >= 24) && (e < 48)) ? 1 : 0;
            sb_q.push_back(ev(st, rt, 0));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reseq_timeout cycle %0d: got %h required %h", e, act, exp);
            end
        end
        reseq_req = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_timeout_fault();
        test_glitch_stable();
        test_loss_in_run();
        test_sync_reset();
        test_reseq_stable();
        test_reseq_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
